// File: rtl/calc_result_checker.sv
// -----------------------------------------------------------------------------
// calc_result_checker
//
// Self-checking response end for the 4-bit Calculator datapath. Every operand
// set presented with in_valid is paired with the Calculator's observed result,
// compared against an internally computed golden result, and tallied. The
// first failing vector of a run is captured. With STOP_ON_FAIL set, the
// checker halts on the first mismatch.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               arm/restart pulse (honoured in IDLE, DONE, HALT)
//   in_valid            operand/result set present this cycle
//   in_a, in_b, in_op   operands and Op applied to the Calculator
//   dut_out, dut_cy     result observed from the Calculator
//   busy/done/halted    state is RUN / DONE / HALT
//   chk_valid, chk_pass one-cycle compare pulse and its verdict
//   pass_cnt, fail_cnt  saturating tallies for the current run
//   fail_seen           sticky mismatch flag for the current run
//   fail_a .. fail_cy   first failing vector and its observed result
//   exp_out, exp_cy     expected result for that first failing vector
// -----------------------------------------------------------------------------
module calc_result_checker #(
  parameter int CNT_W        = 8,
  parameter int NUM_VECTORS  = 16,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             in_op,
  input  logic [3:0]       dut_out,
  input  logic             dut_cy,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             fail_seen,
  output logic [3:0]       fail_a,
  output logic [3:0]       fail_b,
  output logic             fail_op,
  output logic [3:0]       fail_out,
  output logic             fail_cy,
  output logic [3:0]       exp_out,
  output logic             exp_cy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, HALT} state_t;

  localparam logic [CNT_W:0]   NUM_V   = (CNT_W+1)'(NUM_VECTORS);
  localparam bit               LIMITED = (NUM_VECTORS != 0);
  localparam bit               STOP    = (STOP_ON_FAIL != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] vec_cnt;
  logic [4:0]       gold;
  logic             match;
  logic             last_vec;

  // 5-bit golden arithmetic: bit 4 is the carry for add and the borrow for
  // subtract (the 5-bit difference wraps negative exactly when A < B).
  always_comb begin
    gold = 5'd0;
    if (in_op) gold = {1'b0, in_a} - {1'b0, in_b};
    else       gold = {1'b0, in_a} + {1'b0, in_b};
  end

  assign match    = (dut_out == gold[3:0]) && (dut_cy == gold[4]);
  // One bit wider than vec_cnt so the compare cannot wrap.
  assign last_vec = LIMITED && (({1'b0, vec_cnt} + (CNT_W+1)'(1)) == NUM_V);

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign halted = (state == HALT);

  // NOTE: all state below is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the capture registers are cleared by reset too, because they are
      // visible outputs and must read 0 after reset rather than stale data.
      state     <= IDLE;
      vec_cnt   <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      fail_seen <= 1'b0;
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_op   <= 1'b0;
      fail_out  <= '0;
      fail_cy   <= 1'b0;
      exp_out   <= '0;
      exp_cy    <= 1'b0;
    end else begin
      // Compare pulse defaults low; only a check in RUN raises it.
      chk_valid <= 1'b0;
      chk_pass  <= 1'b0;
      case (state)
        RUN: begin
          // start is deliberately ignored while running.
          if (in_valid) begin
            chk_valid <= 1'b1;
            chk_pass  <= match;
            vec_cnt   <= vec_cnt + CNT_W'(1);
            if (match) begin
              if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
              if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_W'(1);
              fail_seen <= 1'b1;
              // Capture only the first mismatch of the run.
              if (!fail_seen) begin
                fail_a   <= in_a;
                fail_b   <= in_b;
                fail_op  <= in_op;
                fail_out <= dut_out;
                fail_cy  <= dut_cy;
                exp_out  <= gold[3:0];
                exp_cy   <= gold[4];
              end
            end
            // Reaching the vector budget wins over halting on a mismatch.
            if (last_vec)               state <= DONE;
            else if (!match && STOP)    state <= HALT;
          end
        end
        default: begin
          // IDLE, DONE, HALT: start (re)arms a fresh run.
          if (start) begin
            state     <= RUN;
            vec_cnt   <= '0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            fail_seen <= 1'b0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_op   <= 1'b0;
            fail_out  <= '0;
            fail_cy   <= 1'b0;
            exp_out   <= '0;
            exp_cy    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_result_checker.sv
// -----------------------------------------------------------------------------
// tb_calc_result_checker
//
// Two checker instances share the operand/result bus and reset but have their
// own start: u_halt (16 vectors, stop on fail) and u_cont (4 vectors, keep
// going). A behavioural model per instance tracks what each should show; all
// outputs are compared after every clock, plus directed spot checks.
// -----------------------------------------------------------------------------
module tb_calc_result_checker;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic start [2];
  logic in_valid, in_op, dut_cy;
  logic [3:0] in_a, in_b, dut_out;

  logic busy [2], done [2], halted [2], chk_valid [2], chk_pass [2];
  logic fail_seen [2], fail_op [2], fail_cy [2], exp_cy [2];
  logic [CNT_W-1:0] pass_cnt [2], fail_cnt [2];
  logic [3:0] fail_a [2], fail_b [2], fail_out [2], exp_out [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_result_checker #(.CNT_W(CNT_W), .NUM_VECTORS(16), .STOP_ON_FAIL(1)) u_halt (
    .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .dut_out(dut_out), .dut_cy(dut_cy),
    .busy(busy[0]), .done(done[0]), .halted(halted[0]),
    .chk_valid(chk_valid[0]), .chk_pass(chk_pass[0]),
    .pass_cnt(pass_cnt[0]), .fail_cnt(fail_cnt[0]), .fail_seen(fail_seen[0]),
    .fail_a(fail_a[0]), .fail_b(fail_b[0]), .fail_op(fail_op[0]),
    .fail_out(fail_out[0]), .fail_cy(fail_cy[0]),
    .exp_out(exp_out[0]), .exp_cy(exp_cy[0])
  );

  calc_result_checker #(.CNT_W(CNT_W), .NUM_VECTORS(4), .STOP_ON_FAIL(0)) u_cont (
    .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .dut_out(dut_out), .dut_cy(dut_cy),
    .busy(busy[1]), .done(done[1]), .halted(halted[1]),
    .chk_valid(chk_valid[1]), .chk_pass(chk_pass[1]),
    .pass_cnt(pass_cnt[1]), .fail_cnt(fail_cnt[1]), .fail_seen(fail_seen[1]),
    .fail_a(fail_a[1]), .fail_b(fail_b[1]), .fail_op(fail_op[1]),
    .fail_out(fail_out[1]), .fail_cy(fail_cy[1]),
    .exp_out(exp_out[1]), .exp_cy(exp_cy[1])
  );

  // ---------------------------------------------------------------- model
  typedef enum {M_IDLE, M_RUN, M_DONE, M_HALT} mode_t;
  typedef struct {
    mode_t mode;
    int    npass, nfail, nvec;
    bit    seen, cv, cp;
    int    fa, fb, fop, fo, fcy, eo, ecy;
  } model_t;

  model_t m [2];

  function automatic model_t fresh(mode_t md);
    model_t r;
    r.mode = md;  r.npass = 0; r.nfail = 0; r.nvec = 0;
    r.seen = 1'b0; r.cv = 1'b0; r.cp = 1'b0;
    r.fa = 0; r.fb = 0; r.fop = 0; r.fo = 0; r.fcy = 0; r.eo = 0; r.ecy = 0;
    return r;
  endfunction

  function automatic int num_vec(int i);
    return (i == 0) ? 16 : 4;
  endfunction

  function automatic bit stops(int i);
    return (i == 0);
  endfunction

  // Calculator reference: add with carry, subtract with borrow, 4-bit result.
  function automatic void golden(input int a, input int b, input int op,
                                 output int eo, output int ecy);
    int s;
    s   = op ? (a - b) : (a + b);
    eo  = (s + 16) % 16;
    ecy = op ? int'(a < b) : int'(s > 15);
  endfunction

  task automatic model_step(input int i);
    int eo, ecy;
    bit ok;
    if (rst) begin
      m[i] = fresh(M_IDLE);
      return;
    end
    m[i].cv = 1'b0;
    m[i].cp = 1'b0;
    if (m[i].mode == M_RUN) begin
      if (in_valid) begin
        golden(int'(in_a), int'(in_b), int'(in_op), eo, ecy);
        ok = (int'(dut_out) == eo) && (int'(dut_cy) == ecy);
        m[i].cv = 1'b1;
        m[i].cp = ok;
        m[i].nvec++;
        if (ok) m[i].npass = (m[i].npass < 255) ? m[i].npass + 1 : 255;
        else    m[i].nfail = (m[i].nfail < 255) ? m[i].nfail + 1 : 255;
        if (!ok && !m[i].seen) begin
          m[i].fa = int'(in_a); m[i].fb = int'(in_b); m[i].fop = int'(in_op);
          m[i].fo = int'(dut_out); m[i].fcy = int'(dut_cy);
          m[i].eo = eo; m[i].ecy = ecy;
        end
        if (!ok) m[i].seen = 1'b1;
        if (num_vec(i) != 0 && m[i].nvec == num_vec(i)) m[i].mode = M_DONE;
        else if (!ok && stops(i))                         m[i].mode = M_HALT;
      end
    end else if (start[i]) begin
      m[i] = fresh(M_RUN);
    end
  endtask

  // ---------------------------------------------------------------- checks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic check_all(input string ph);
    for (int i = 0; i < 2; i++) begin
      string p;
      p = $sformatf("%s[%0d]", ph, i);
      check({p, ".busy"},      32'(busy[i]),      32'(m[i].mode == M_RUN));
      check({p, ".done"},      32'(done[i]),      32'(m[i].mode == M_DONE));
      check({p, ".halted"},    32'(halted[i]),    32'(m[i].mode == M_HALT));
      check({p, ".chk_valid"}, 32'(chk_valid[i]), 32'(m[i].cv));
      check({p, ".chk_pass"},  32'(chk_pass[i]),  32'(m[i].cp));
      check({p, ".pass_cnt"},  32'(pass_cnt[i]),  m[i].npass);
      check({p, ".fail_cnt"},  32'(fail_cnt[i]),  m[i].nfail);
      check({p, ".fail_seen"}, 32'(fail_seen[i]), 32'(m[i].seen));
      check({p, ".fail_a"},    32'(fail_a[i]),    m[i].fa);
      check({p, ".fail_b"},    32'(fail_b[i]),    m[i].fb);
      check({p, ".fail_op"},   32'(fail_op[i]),   m[i].fop);
      check({p, ".fail_out"},  32'(fail_out[i]),  m[i].fo);
      check({p, ".fail_cy"},   32'(fail_cy[i]),   m[i].fcy);
      check({p, ".exp_out"},   32'(exp_out[i]),   m[i].eo);
      check({p, ".exp_cy"},    32'(exp_cy[i]),    m[i].ecy);
    end
  endtask

  // One clock: drive inputs, advance the models at the edge, compare #1 later.
  task automatic step(input string ph, input bit s0, input bit s1, input bit v,
                      input int a, input int b, input int op, input int o, input int c);
    start[0] = s0;  start[1] = s1;  in_valid = v;
    in_a = 4'(a);   in_b = 4'(b);   in_op = 1'(op);
    dut_out = 4'(o); dut_cy = 1'(c);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all(ph);
  endtask

  task automatic vec(input string ph, input int a, input int b, input int op,
                     input int o, input int c);
    step(ph, 1'b0, 1'b0, 1'b1, a, b, op, o, c);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int a, b, op, eo, ecy, o, c;
    bit s0, s1, v;

    m[0] = fresh(M_IDLE);
    m[1] = fresh(M_IDLE);
    rst = 1'b1;
    step("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset.pass_cnt", 32'(pass_cnt[0]), 0);
    check("reset.busy",     32'(busy[0]),     0);
    rst = 1'b0;

    // in_valid while idle must produce nothing.
    vec("idle_valid", 4, 3, 1, 1, 0);
    check("idle_valid.chk_valid", 32'(chk_valid[0]), 0);

    // Basic passes, carry and borrow on the stop-on-fail instance.
    step("start0", 1, 0, 0, 0, 0, 0, 0, 0);
    vec("sub_pass", 4, 3, 1, 1, 0);
    check("sub_pass.chk_pass", 32'(chk_pass[0]), 1);
    vec("add_pass", 8, 2, 0, 10, 0);
    check("basic.pass_cnt",  32'(pass_cnt[0]),  2);
    check("basic.fail_cnt",  32'(fail_cnt[0]),  0);
    check("basic.fail_seen", 32'(fail_seen[0]), 0);
    vec("carry", 9, 8, 0, 1, 1);
    vec("borrow", 2, 5, 1, 13, 1);
    check("carry_borrow.pass_cnt", 32'(pass_cnt[0]), 4);

    // start during RUN is ignored; the vector still counts.
    step("start_in_run", 1, 0, 1, 1, 1, 0, 2, 0);
    check("start_in_run.pass_cnt", 32'(pass_cnt[0]), 5);

    // First mismatch halts; the next vector is ignored.
    vec("halt_fail", 4, 3, 1, 7, 0);
    check("halt.halted",   32'(halted[0]),   1);
    check("halt.fail_cnt", 32'(fail_cnt[0]), 1);
    check("halt.fail_out", 32'(fail_out[0]), 7);
    check("halt.exp_out",  32'(exp_out[0]),  1);
    vec("after_halt", 4, 3, 1, 1, 0);
    check("after_halt.pass_cnt",  32'(pass_cnt[0]),  5);
    check("after_halt.chk_valid", 32'(chk_valid[0]), 0);

    // Keep-going instance: fail, pass, fail, pass -> DONE.
    step("start1", 0, 1, 0, 0, 0, 0, 0, 0);
    vec("cont_f1", 9, 8, 0, 1, 0);
    vec("cont_p1", 2, 5, 1, 13, 1);
    vec("cont_f2", 2, 5, 1, 13, 0);
    vec("cont_p2", 4, 3, 1, 1, 0);
    check("cont.done",     32'(done[1]),     1);
    check("cont.pass_cnt", 32'(pass_cnt[1]), 2);
    check("cont.fail_cnt", 32'(fail_cnt[1]), 2);
    check("cont.fail_a",   32'(fail_a[1]),   9);
    check("cont.fail_cy",  32'(fail_cy[1]),  0);
    check("cont.exp_cy",   32'(exp_cy[1]),   1);

    // start in DONE clears and re-arms.
    step("restart_done", 0, 1, 0, 0, 0, 0, 0, 0);
    check("restart.busy",      32'(busy[1]),      1);
    check("restart.fail_cnt",  32'(fail_cnt[1]),  0);
    check("restart.fail_seen", 32'(fail_seen[1]), 0);
    check("restart.fail_a",    32'(fail_a[1]),    0);

    // rst mid-run with in_valid high.
    step("rerun0", 1, 0, 0, 0, 0, 0, 0, 0);
    vec("pre_rst", 3, 3, 0, 6, 0);
    rst = 1'b1;
    vec("mid_rst", 3, 3, 0, 6, 0);
    check("mid_rst.busy",      32'(busy[0]),      0);
    check("mid_rst.pass_cnt",  32'(pass_cnt[0]),  0);
    check("mid_rst.chk_valid", 32'(chk_valid[0]), 0);
    rst = 1'b0;

    // Randomized traffic with occasional corruption, starts and resets.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      s0  = ($urandom_range(0, 9) == 0);
      s1  = ($urandom_range(0, 9) == 0);
      v   = ($urandom_range(0, 3) != 0);
      a   = int'($urandom_range(0, 15));
      b   = int'($urandom_range(0, 15));
      op  = int'($urandom_range(0, 1));
      golden(a, b, op, eo, ecy);
      o = eo;
      c = ecy;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) o = eo ^ int'($urandom_range(1, 15));
        else                           c = 1 - ecy;
      end
      step("random", s0, s1, v, a, b, op, o, c);
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_result_checker.md
Name: calc_result_checker

Overview:
- Self-checking response end for the 4-bit Calculator datapath.
- Consumes every applied operand set (A, B, Op) together with the Calculator's observed result (Out, cy), computes the golden result internally, and compares the two.
- Tallies passes and failures, captures the first failing vector, and optionally halts the run on the first failure.
- Used in simulation benches and on-board self-test, downstream of whatever drives the Calculator.

Parameters:
- CNT_W, 8: width of the pass, fail and vector counters.
- NUM_VECTORS, 16: number of checks per run; 0 = unlimited (never reaches DONE).
- STOP_ON_FAIL, 1: 1 = enter HALT on the first mismatch; 0 = keep checking.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  arm/restart pulse
- in_valid  in  1  operand/result set present this cycle
- in_a  in  4  operand A applied to the Calculator
- in_b  in  4  operand B applied to the Calculator
- in_op  in  1  Op applied to the Calculator
- dut_out  in  4  Calculator Out
- dut_cy  in  1  Calculator cy
- busy  out  1  state is RUN
- done  out  1  state is DONE
- halted  out  1  state is HALT
- chk_valid  out  1  one-cycle pulse: a compare result is presented
- chk_pass  out  1  result of that compare; meaningful only with chk_valid
- pass_cnt  out  CNT_W  passing checks this run
- fail_cnt  out  CNT_W  failing checks this run
- fail_seen  out  1  sticky: at least one mismatch this run
- fail_a, fail_b  out  4 each  operands of the first failure
- fail_op  out  1  Op of the first failure
- fail_out, fail_cy  out  4, 1  observed result of the first failure
- exp_out, exp_cy  out  4, 1  expected result of the first failure

Behaviour:
- Golden model, 5-bit internal arithmetic:
  - Op=0: {exp_cy, exp_out} = A + B; cy = carry out.
  - Op=1: exp_out = (A - B) mod 16; exp_cy = 1 iff A < B (borrow).
- Pass condition: dut_out == expected Out and dut_cy == expected cy.
- Reset (synchronous, rst high at the edge):
  - state = IDLE.
  - All outputs 0: counters, flags, pulses and capture registers.
- State machine, states IDLE, RUN, DONE, HALT:
  - IDLE: start -> RUN.
  - RUN: each edge with in_valid=1 performs one check.
    - If vec_cnt+1 == NUM_VECTORS (NUM_VECTORS != 0) -> DONE.
    - Else if mismatch and STOP_ON_FAIL=1 -> HALT.
    - DONE takes priority when both conditions hold on the same check.
  - DONE, HALT: start -> RUN.
  - start while in RUN is ignored.
- Entering RUN from any state clears pass_cnt, fail_cnt, vec_cnt, fail_seen and all fail_*/exp_* captures in the same edge.
- in_valid is ignored outside RUN; no counting and no chk_valid.
- Latency:
  - Inputs sampled at edge k (state RUN, in_valid=1).
  - chk_valid/chk_pass high for exactly the cycle following edge k.
  - Counters and captures are updated at edge k.
  - The compare is purely registered, so no vector is in flight when the state changes.
- Back-to-back in_valid every cycle is supported at full rate.
- Counters:
  - pass_cnt and fail_cnt saturate at 2^CNT_W-1.
  - The internal vec_cnt used for DONE does not saturate before NUM_VECTORS.
  - NUM_VECTORS must be <= 2^CNT_W-1.
- Capture: the fail_*/exp_* registers load only on the first mismatch of a run (fail_seen was 0). Later mismatches do not overwrite them.
- rst asserted mid-run overrides everything: state returns to IDLE and all outputs clear. rst has priority over start.

Test Plan:
- Reset, start, then check (A=4, B=3, Op=1, out=1, cy=0) and (A=8, B=2, Op=0, out=10, cy=0) -> two chk_pass=1 pulses; pass_cnt=2, fail_cnt=0, fail_seen=0.
- Carry and borrow: (A=9, B=8, Op=0, out=1, cy=1) and (A=2, B=5, Op=1, out=4'hD, cy=1) -> both pass. A wrong cy on either one -> fail.
- STOP_ON_FAIL=1: (A=4, B=3, Op=1, out=7, cy=0) followed by a valid vector on the next cycle:
  - halted=1, fail_cnt=1, fail_out=7, exp_out=1.
  - The next vector is ignored; pass_cnt is unchanged.
- STOP_ON_FAIL=0, NUM_VECTORS=4: fail, pass, fail, pass:
  - done=1 after the 4th check; pass_cnt=2, fail_cnt=2.
  - Capture holds the first failure only.
- Sequencing edge cases:
  - in_valid while IDLE -> no chk_valid.
  - start during RUN -> ignored.
  - start in DONE -> counters and captures clear, state RUN.
- rst pulsed mid-run with in_valid=1 -> the next cycle shows state IDLE, all counters 0, chk_valid=0.
